instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage that sits directly upstream of the CPU execute core. It holds the program counter, reads 16-bit instruction words from instruction memory over a request/acknowledge handshake, and latches each word into an instruction register. It presents the decoded fields I, opcode and IR_address to the CPU behind a valid/ready handshake. The CPU can redirect fetch to a new address for jumps, branches and skips. While the CPU is not ready, the fetch unit holds the current instruction stable.

## Interface
- RESET_PC, 12'h000, program counter value loaded on reset
- clk  input  1  system clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- halt  input  1  while 1, no new memory request is started
- mem_rd  output  1  instruction memory read request
- mem_addr  output  12  read address; always equals PC
- mem_ack  input  1  memory has valid data on mem_rdata this cycle
- mem_rdata  input  16  instruction word: [15]=I, [14:12]=opcode, [11:0]=address
- out_valid  output  1  instruction fields are valid
- out_ready  input  1  CPU accepts the instruction
- I  output  1  indirect bit (IR[15])
- opcode  output  3  IR[14:12]
- IR_address  output  12  IR[11:0]
- redirect  input  1  load PC from redirect_addr and discard any in-flight or held instruction
- redirect_addr  input  12  new fetch address
- pc  output  12  current program counter (debug)

## Operation
- State machine states:
  - IDLE: no activity.
  - FETCH: mem_rd=1.
  - HOLD: out_valid=1.
- While reset=0: state=IDLE, PC=RESET_PC, IR=16'h0000, mem_rd=0, out_valid=0. I, opcode and IR_address are therefore all 0.
- IDLE -> FETCH on the first edge with halt=0.
- FETCH:
  - mem_rd=1 and mem_addr=PC are held steady until mem_ack.
  - On an edge with mem_ack=1: IR<=mem_rdata, PC<=PC+1 (12-bit, 12'hFFF wraps to 12'h000), then go to HOLD.
  - mem_ack is ignored whenever mem_rd=0.
- HOLD:
  - out_valid=1; I, opcode and IR_address are taken directly from IR and do not change.
  - On an edge with out_ready=1: go to FETCH if halt=0, otherwise go to IDLE.
- Halt:
  - halt is sampled only when leaving IDLE or HOLD.
  - A fetch already in progress (FETCH state) always completes.
- Redirect (highest priority, any state except reset):
  - On an edge with redirect=1: PC<=redirect_addr, IR is unchanged, out_valid drops, next state is FETCH (or IDLE if halt=1).
  - A mem_ack in the same cycle is discarded and PC+1 is not applied.
  - A HOLD handshake in the same cycle (out_ready=1) is not counted as an acceptance by this block; the CPU must not issue redirect and consume on the same cycle.
- The memory is required to tolerate mem_rd dropping in the cycle after mem_ack. Back-to-back requests to consecutive addresses are legal.

## Timing
- Reset deassertion is synchronised by the existing top-level reset logic. The first edge after release enters FETCH, and mem_rd=1 in the following cycle.
- Fetch latency: mem_ack at edge N gives out_valid=1 from just after edge N (registered; visible cycle N+1).
- Acceptance at edge M (out_valid & out_ready) gives mem_rd=1 in cycle M+1 with the incremented address.
- Best-case throughput with single-cycle mem_ack and out_ready tied to 1: one instruction every 2 cycles.
- All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.
- Async reset asserted mid-fetch or mid-hold: all outputs return to their reset values immediately, without waiting for a clock edge.

## Test plan
- Reset, sequential fetch:
  - Stimulus: memory holds 16'h0001 at address 0 and 16'hB68A at address 1; release reset; ack after 1 cycle; out_ready=1.
  - Required response: outputs (I,opcode,IR_address) = (0,000,12'h001), then (1,011,12'h68A); pc steps 0 -> 1 -> 2.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles after out_valid.
  - Required response: mem_rd=0 and the fields stay stable throughout; exactly one mem_rd pulse occurs after out_ready rises.
- Slow memory:
  - Stimulus: mem_ack delayed 3 cycles.
  - Required response: mem_rd and mem_addr stay constant for all 4 cycles; IR captures only on the ack cycle.
- Redirect:
  - Stimulus: redirect=1 with redirect_addr=12'h0C5 during HOLD; in a second case, assert redirect in the same cycle as mem_ack.
  - Required response: out_valid drops; the next mem_addr is 12'h0C5; the acked word is discarded.
- Wrap and halt:
  - Stimulus: redirect to 12'hFFF and fetch; then assert halt during HOLD.
  - Required response: pc wraps to 12'h000; after acceptance the block enters IDLE with mem_rd=0; on halt release the next request is to address 12'h000.
- Mid-operation reset:
  - Stimulus: drive reset=0 while mem_rd=1.
  - Required response: mem_rd, out_valid and all fields go to 0 asynchronously; pc=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: program counter, memory read handshake, instruction
// register, and valid/ready presentation of the decoded fields to the CPU.
module instr_fetch_unit #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        halt,
  output logic        mem_rd,
  output logic [11:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        I,
  output logic [2:0]  opcode,
  output logic [11:0] IR_address,
  input  logic        redirect,
  input  logic [11:0] redirect_addr,
  output logic [11:0] pc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state_q;
  logic [11:0] pc_q;
  logic [15:0] ir_q;
  logic        mem_rd_q;
  logic        out_valid_q;

  // mem_rd/out_valid are registered alongside the state so they always
  // equal the state decode without any input-to-output path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      ir_q        <= 16'h0000;
      mem_rd_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (redirect) begin
      // Redirect wins over any ack or acceptance in the same cycle.
      pc_q        <= redirect_addr;
      out_valid_q <= 1'b0;
      if (halt) begin
        state_q  <= IDLE;
        mem_rd_q <= 1'b0;
      end else begin
        state_q  <= FETCH;
        mem_rd_q <= 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (!halt) begin
            state_q  <= FETCH;
            mem_rd_q <= 1'b1;
          end
        end
        FETCH: begin
          if (mem_ack) begin
            ir_q        <= mem_rdata;
            pc_q        <= pc_q + 12'd1;
            state_q     <= HOLD;
            mem_rd_q    <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (halt) begin
              state_q <= IDLE;
            end else begin
              state_q  <= FETCH;
              mem_rd_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          mem_rd_q    <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_rd     = mem_rd_q;
  assign mem_addr   = pc_q;
  assign out_valid  = out_valid_q;
  assign I          = ir_q[15];
  assign opcode     = ir_q[14:12];
  assign IR_address = ir_q[11:0];
  assign pc         = pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequential fetch, backpressure, slow
// memory, redirects, PC wrap with halt, and asynchronous reset mid-fetch.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        halt;
  logic        mem_rd;
  logic [11:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic        I;
  logic [2:0]  opcode;
  logic [11:0] IR_address;
  logic        redirect;
  logic [11:0] redirect_addr;
  logic [11:0] pc;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit #(.RESET_PC(12'h000)) dut (
    .clk           (clk),
    .reset         (reset),
    .halt          (halt),
    .mem_rd        (mem_rd),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .I             (I),
    .opcode        (opcode),
    .IR_address    (IR_address),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .pc            (pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks every output at once; one line per transaction.
  task automatic check_all(input string tag, input logic exp_valid, input logic exp_rd,
                           input logic [11:0] exp_maddr, input logic exp_i,
                           input logic [2:0] exp_op, input logic [11:0] exp_ira,
                           input logic [11:0] exp_pc);
    check({tag, ".out_valid"}, {15'd0, out_valid}, {15'd0, exp_valid});
    check({tag, ".mem_rd"}, {15'd0, mem_rd}, {15'd0, exp_rd});
    check({tag, ".mem_addr"}, {4'd0, mem_addr}, {4'd0, exp_maddr});
    check({tag, ".I"}, {15'd0, I}, {15'd0, exp_i});
    check({tag, ".opcode"}, {13'd0, opcode}, {13'd0, exp_op});
    check({tag, ".IR_address"}, {4'd0, IR_address}, {4'd0, exp_ira});
    check({tag, ".pc"}, {4'd0, pc}, {4'd0, exp_pc});
    $display("%s: valid=%0b rd=%0b maddr=%h I=%0b op=%0d ira=%h pc=%h",
             tag, out_valid, mem_rd, mem_addr, I, opcode, IR_address, pc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; halt = 1'b0; mem_ack = 1'b0; mem_rdata = 16'h0000;
    out_ready = 1'b1; redirect = 1'b0; redirect_addr = 12'h000;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 0, 12'h000, 0, 3'd0, 12'h000, 12'h000);

    // Sequential fetch
    reset = 1'b1;
    step();
    check_all("fetch0_req", 0, 1, 12'h000, 0, 3'd0, 12'h000, 12'h000);
    mem_ack = 1'b1; mem_rdata = 16'h0001;
    step();
    mem_ack = 1'b0;
    check_all("fetch0_hold", 1, 0, 12'h001, 0, 3'd0, 12'h001, 12'h001);
    step();
    check_all("fetch1_req", 0, 1, 12'h001, 0, 3'd0, 12'h001, 12'h001);
    mem_ack = 1'b1; mem_rdata = 16'hB68A;
    step();
    mem_ack = 1'b0;
    check_all("fetch1_hold", 1, 0, 12'h002, 1, 3'd3, 12'h68A, 12'h002);

    // Backpressure
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_all("backpressure", 1, 0, 12'h002, 1, 3'd3, 12'h68A, 12'h002);
    end
    out_ready = 1'b1;
    step();
    check_all("bp_release", 0, 1, 12'h002, 1, 3'd3, 12'h68A, 12'h002);

    // Slow memory: ack arrives on the fourth request cycle
    for (int i = 0; i < 3; i++) begin
      step();
      check_all("slow_wait", 0, 1, 12'h002, 1, 3'd3, 12'h68A, 12'h002);
    end
    mem_ack = 1'b1; mem_rdata = 16'h7123;
    step();
    mem_ack = 1'b0;
    check_all("slow_ack", 1, 0, 12'h003, 0, 3'd7, 12'h123, 12'h003);

    // Redirect during HOLD
    out_ready = 1'b0; redirect = 1'b1; redirect_addr = 12'h0C5;
    step();
    redirect = 1'b0;
    check_all("redir_hold", 0, 1, 12'h0C5, 0, 3'd7, 12'h123, 12'h0C5);

    // Redirect in the same cycle as mem_ack: acked word is dropped
    mem_ack = 1'b1; mem_rdata = 16'hFFFF; redirect = 1'b1; redirect_addr = 12'h200;
    step();
    redirect = 1'b0; mem_rdata = 16'h1234;
    check_all("redir_ack", 0, 1, 12'h200, 0, 3'd7, 12'h123, 12'h200);
    step();
    mem_ack = 1'b0;
    check_all("redir_refetch", 1, 0, 12'h201, 0, 3'd1, 12'h234, 12'h201);

    // Wrap at 12'hFFF
    redirect = 1'b1; redirect_addr = 12'hFFF;
    step();
    redirect = 1'b0;
    check_all("wrap_req", 0, 1, 12'hFFF, 0, 3'd1, 12'h234, 12'hFFF);
    mem_ack = 1'b1; mem_rdata = 16'h8ABC;
    step();
    mem_ack = 1'b0;
    check_all("wrap_hold", 1, 0, 12'h000, 1, 3'd0, 12'hABC, 12'h000);

    // Halt during HOLD: acceptance goes to IDLE
    halt = 1'b1; out_ready = 1'b1;
    step();
    check_all("halt_idle", 0, 0, 12'h000, 1, 3'd0, 12'hABC, 12'h000);
    for (int i = 0; i < 2; i++) begin
      step();
      check_all("halt_stay", 0, 0, 12'h000, 1, 3'd0, 12'hABC, 12'h000);
    end
    halt = 1'b0;
    step();
    check_all("halt_release", 0, 1, 12'h000, 1, 3'd0, 12'hABC, 12'h000);

    // Asynchronous reset mid-fetch, away from any clock edge
    #2;
    reset = 1'b0;
    #1;
    check_all("async_reset", 0, 0, 12'h000, 0, 3'd0, 12'h000, 12'h000);
    step();
    reset = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
